// File: rtl/exe_iter.sv
// Execute stage for RV32I OP-IMM instructions. Shifts by a non-zero amount are
// iterative, one bit per cycle, and stall the upstream pipeline until the last step.
module exe_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] inst_i,
    output logic        stall_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [31:0] sh_val;
    logic        sh_left;
    logic        sh_arith;
    logic        sh_we;
    logic [4:0]  sh_waddr;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  shamt;
    logic        dec_ok;
    logic        dec_shift;
    logic        dec_left;
    logic        dec_arith;
    logic [31:0] dec_res;
    logic        start_shift;
    logic [31:0] sh_next;
    logic        unused_bits;

    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign funct7      = inst_i[31:25];
    assign shamt       = op2_i[4:0];
    assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        dec_ok    = 1'b0;
        dec_shift = 1'b0;
        dec_left  = 1'b0;
        dec_arith = 1'b0;
        dec_res   = 32'd0;
        if (opcode == OPC_IMM) begin
            case (funct3)
                3'b000: begin dec_ok = 1'b1; dec_res = op1_i + op2_i; end
                3'b010: begin dec_ok = 1'b1; dec_res = {31'd0, $signed(op1_i) < $signed(op2_i)}; end
                3'b011: begin dec_ok = 1'b1; dec_res = {31'd0, op1_i < op2_i}; end
                3'b100: begin dec_ok = 1'b1; dec_res = op1_i ^ op2_i; end
                3'b110: begin dec_ok = 1'b1; dec_res = op1_i | op2_i; end
                3'b111: begin dec_ok = 1'b1; dec_res = op1_i & op2_i; end
                3'b001: begin
                    // A zero-amount shift completes in one cycle with op1 unchanged.
                    if (funct7 == F7_ZERO) begin
                        dec_ok = 1'b1; dec_shift = 1'b1; dec_left = 1'b1; dec_res = op1_i;
                    end
                end
                default: begin
                    if (funct7 == F7_ZERO || funct7 == F7_SRA) begin
                        dec_ok = 1'b1; dec_shift = 1'b1; dec_res = op1_i;
                        dec_arith = (funct7 == F7_SRA);
                    end
                end
            endcase
        end
    end

    assign start_shift = (state == S_IDLE) && dec_shift && (shamt != 5'd0);
    assign sh_next     = sh_left ? {sh_val[30:0], 1'b0} : {sh_arith & sh_val[31], sh_val[31:1]};

    // Stall drops in the final shift cycle so the next instruction arrives as we return to idle.
    assign stall_o = !rst_i && (start_shift || ((state == S_SHIFT) && (cnt != 5'd1)));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= 5'd0;
            sh_val      <= 32'd0;
            sh_left     <= 1'b0;
            sh_arith    <= 1'b0;
            sh_we       <= 1'b0;
            sh_waddr    <= 5'd0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_shift) begin
                        state       <= S_SHIFT;
                        cnt         <= shamt;
                        sh_val      <= op1_i;
                        sh_left     <= dec_left;
                        sh_arith    <= dec_arith;
                        sh_we       <= reg_we_i;
                        sh_waddr    <= reg_waddr_i;
                        reg_we_o    <= 1'b0;
                        reg_waddr_o <= 5'd0;
                        reg_wdata_o <= 32'd0;
                    end else if (dec_ok) begin
                        reg_we_o    <= reg_we_i && (reg_waddr_i != 5'd0);
                        reg_waddr_o <= reg_waddr_i;
                        reg_wdata_o <= dec_res;
                    end else begin
                        reg_we_o    <= 1'b0;
                        reg_waddr_o <= 5'd0;
                        reg_wdata_o <= 32'd0;
                    end
                end
                default: begin
                    sh_val <= sh_next;
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state       <= S_IDLE;
                        reg_we_o    <= sh_we && (sh_waddr != 5'd0);
                        reg_waddr_o <= sh_waddr;
                        reg_wdata_o <= sh_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_iter.sv
// Self-checking bench for exe_iter: directed cases then random OP-IMM traffic
// compared against a whole-instruction reference model.
module tb_exe_iter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] inst_i;
    logic        stall_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int total = 0;
    int bad   = 0;

    exe_iter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_we_i    (reg_we_i),
        .reg_waddr_i (reg_waddr_i),
        .inst_i      (inst_i),
        .stall_o     (stall_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd0, 5'd1, f3, 5'd0, 7'b0010011};
    endfunction

    // Reference: whole result in one step; n is the number of extra cycles a shift takes.
    task automatic model(input logic [31:0] inst, input logic [31:0] op1, input logic [31:0] op2,
                         input logic we, input logic [4:0] wa, output int n,
                         output logic e_we, output logic [4:0] e_wa, output logic [31:0] e_wd);
        logic [6:0]  f7;
        logic [4:0]  sh;
        logic        valid;
        logic [31:0] r;
        f7 = inst[31:25];
        sh = op2[4:0];
        n = 0;
        valid = 1'b1;
        r = 32'd0;
        if (inst[6:0] != 7'b0010011) valid = 1'b0;
        else begin
            case (inst[14:12])
                3'd0: r = op1 + op2;
                3'd2: r = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
                3'd3: r = (op1 < op2) ? 32'd1 : 32'd0;
                3'd4: r = op1 ^ op2;
                3'd6: r = op1 | op2;
                3'd7: r = op1 & op2;
                3'd1: if (f7 == 7'h00) begin r = op1 << sh; n = int'(sh); end else valid = 1'b0;
                default: begin
                    if (f7 == 7'h00) begin r = op1 >> sh; n = int'(sh); end
                    else if (f7 == 7'h20) begin r = $unsigned($signed(op1) >>> sh); n = int'(sh); end
                    else valid = 1'b0;
                end
            endcase
        end
        e_we = valid && we && (wa != 5'd0);
        e_wa = valid ? wa : 5'd0;
        e_wd = valid ? r : 32'd0;
    endtask

    // Called just after a rising edge; returns just after the edge that makes the result visible.
    task automatic run_op(input logic [31:0] inst, input logic [31:0] op1, input logic [31:0] op2,
                          input logic we, input logic [4:0] wa);
        int          n;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        model(inst, op1, op2, we, wa, n, e_we, e_wa, e_wd);
        inst_i = inst; op1_i = op1; op2_i = op2; reg_we_i = we; reg_waddr_i = wa;
        for (int k = 0; k <= n; k++) begin
            #1;
            check("stall", {31'd0, stall_o}, {31'd0, (n > 0) && (k < n)});
            if (k >= 1) check("busy_we", {31'd0, reg_we_o}, 32'd0);
            @(posedge clk_i);
            #1;
            // Inputs are don't-care while shifting.
            if (k == 0 && n > 0) begin
                inst_i = $urandom; op1_i = $urandom; op2_i = $urandom;
                reg_we_i = 1'b1; reg_waddr_i = 5'd31;
            end
        end
        check("res_we", {31'd0, reg_we_o}, {31'd0, e_we});
        check("res_waddr", {27'd0, reg_waddr_o}, {27'd0, e_wa});
        check("res_wdata", reg_wdata_o, e_wd);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] inst;

        rst_i = 1'b1;
        inst_i = mk(7'h20, 3'd5); op1_i = 32'h8000_0000; op2_i = 32'd4;
        reg_we_i = 1'b1; reg_waddr_i = 5'd5;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_we", {31'd0, reg_we_o}, 32'd0);
        check("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        check("rst_wdata", reg_wdata_o, 32'd0);
        rst_i = 1'b0;

        run_op(mk(7'h00, 3'd0), 32'd5, 32'hFFFF_FFFD, 1'b1, 5'd3);
        check("addi_x3", reg_wdata_o, 32'd2);
        run_op(mk(7'h00, 3'd2), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd4);
        check("slti", reg_wdata_o, 32'd1);
        run_op(mk(7'h00, 3'd3), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd4);
        check("sltiu", reg_wdata_o, 32'd0);
        run_op(mk(7'h20, 3'd5), 32'h8000_0000, 32'd4, 1'b1, 5'd5);
        check("srai_x5", reg_wdata_o, 32'hF800_0000);
        run_op(mk(7'h00, 3'd1), 32'h0000_1234, 32'd0, 1'b1, 5'd6);
        check("slli_sh0", reg_wdata_o, 32'h0000_1234);

        // Reset in the third shift cycle aborts the shift.
        inst_i = mk(7'h00, 3'd5); op1_i = 32'hDEAD_BEEF; op2_i = 32'd8;
        reg_we_i = 1'b1; reg_waddr_i = 5'd12;
        #1;
        check("srl_accept_stall", {31'd0, stall_o}, 32'd1);
        repeat (3) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        inst_i = mk(7'h00, 3'd0); op1_i = 32'd1; op2_i = 32'd1; reg_we_i = 1'b1; reg_waddr_i = 5'd7;
        #1;
        check("abort_we", {31'd0, reg_we_o}, 32'd0);
        check("abort_waddr", {27'd0, reg_waddr_o}, 32'd0);
        check("abort_wdata", reg_wdata_o, 32'd0);
        check("abort_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        check("after_abort_we", {31'd0, reg_we_o}, 32'd1);
        check("after_abort_waddr", {27'd0, reg_waddr_o}, 32'd7);
        check("after_abort_wdata", reg_wdata_o, 32'd2);

        run_op(mk(7'h00, 3'd1), 32'd1, 32'd1, 1'b1, 5'd8);
        check("slli_x8", reg_wdata_o, 32'd2);
        run_op(mk(7'h00, 3'd0), 32'd10, 32'd1, 1'b1, 5'd9);
        check("addi_x9", reg_wdata_o, 32'd11);
        run_op(mk(7'h00, 3'd0), 32'd10, 32'd1, 1'b1, 5'd0);
        check("addi_x0_we", {31'd0, reg_we_o}, 32'd0);
        run_op(mk(7'h00, 3'd1), 32'd3, 32'd2, 1'b1, 5'd0);
        run_op({7'h00, 5'd0, 5'd1, 3'd0, 5'd0, 7'b0110011}, 32'd4, 32'd5, 1'b1, 5'd10);
        run_op(mk(7'h20, 3'd1), 32'd4, 32'd5, 1'b1, 5'd10);
        run_op(mk(7'h01, 3'd5), 32'd4, 32'd5, 1'b1, 5'd10);
        run_op(mk(7'h00, 3'd5), 32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 5'd11);

        for (int i = 0; i < 150; i++) begin
            rnd = $urandom;
            f3 = rnd[2:0];
            f7 = rnd[9:3];
            if ((f3 == 3'd1 || f3 == 3'd5) && rnd[12:10] != 3'd0) f7 = rnd[13] ? 7'h20 : 7'h00;
            inst = $urandom;
            inst[6:0]   = (rnd[17:14] == 4'd0) ? 7'b0110011 : 7'b0010011;
            inst[14:12] = f3;
            inst[31:25] = f7;
            run_op(inst, $urandom, $urandom, rnd[18], rnd[23:19]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_iter.md
EXE_ITER -- requirements
Module: exe_iter

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; all state changes on posedge.
REQ-002 SHALL have port: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: op1_i  in  32  rs1 operand from id_exe.
REQ-004 SHALL have port: op2_i  in  32  sign-extended immediate from id_exe.
REQ-005 SHALL have port: reg_we_i  in  1  write enable from id_exe.
REQ-006 SHALL have port: reg_waddr_i  in  5  destination register from id_exe.
REQ-007 SHALL have port: inst_i  in  32  instruction word from id_exe; NOP = 32'h00000013.
REQ-008 SHALL have port: stall_o  out  1  hold request to upstream; id_exe and earlier stages keep their contents while 1.
REQ-009 SHALL have port: reg_we_o  out  1  write enable toward writeback.
REQ-010 SHALL have port: reg_waddr_o  out  5  destination register toward writeback.
REQ-011 SHALL have port: reg_wdata_o  out  32  result toward writeback.

Function
REQ-012 SHALL decode only opcode inst_i[6:0]=7'b0010011 by funct3=inst_i[14:12]:
- 000 ADDI
- 010 SLTI (signed)
- 011 SLTIU (unsigned)
- 100 XORI
- 110 ORI
- 111 ANDI
- 001 SLLI
- 101 SRLI if inst_i[30]=0, SRAI if inst_i[30]=1
REQ-013 SHALL use shamt=op2_i[4:0] and ignore op2_i[31:5] for shifts.
REQ-014 SHALL implement a two-state FSM, IDLE and SHIFT; reset state IDLE.
REQ-015 In IDLE, for a non-shift op or a shift with shamt=0, SHALL register the result, reg_we_i and reg_waddr_i at the next edge (latency 1); stall_o=0; FSM stays IDLE.
REQ-016 Add/compare/logic arithmetic SHALL be 32-bit, wrap modulo 2^32; SLT results SHALL be zero-extended 0/1.
REQ-017 In IDLE, a shift with shamt=N>0 SHALL be accepted in cycle T:
- stall_o=1 combinationally in T
- op1, N, direction, arith flag, we and waddr latched
- FSM to SHIFT
- output register loaded with a bubble (we=0, waddr=0, wdata=0)
REQ-018 In SHIFT, SHALL shift the latched value by exactly 1 bit per cycle; SRAI replicates bit 31, SRLI/SLLI fill 0; remaining count decrements each cycle.
REQ-019 SHALL hold stall_o=1 in SHIFT cycles T+1..T+N-1 and drive stall_o=0 in final cycle T+N.
REQ-020 At the edge ending T+N, SHALL register the final shifted value with latched we/waddr and return to IDLE; result visible in cycle T+N+1.
REQ-021 SHALL ignore all inputs while in SHIFT.
REQ-022 SHALL output reg_we_o=0 in every cycle from T+1 through T+N.
REQ-023 Unsupported opcode or funct3/funct7 combination (including NOP-equivalent non-I-type words) SHALL produce a bubble: reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0.
REQ-024 reg_we_o SHALL be forced to 0 whenever reg_waddr is 0 (x0 never written).
REQ-025 A shift following a shift, or an ALU op following a shift, SHALL be accepted in the first IDLE cycle with no lost or duplicated result.

Reset
REQ-026 While rst_i=1 at an edge, SHALL set reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, FSM=IDLE, shift counter=0; stall_o SHALL read 0 in the following cycle.
REQ-027 Reset during SHIFT SHALL abort the shift and discard the latched operation; no partial result is ever written.
REQ-028 Reset SHALL take priority over acceptance of any instruction in the same cycle.

Verification
REQ-029 ADDI x3: op1=5, op2=32'hFFFFFFFD -> next cycle we=1, waddr=3, wdata=2, stall_o never 1.
REQ-030 op1=32'hFFFFFFFF, op2=1: SLTI x4 -> wdata=1; SLTIU x4 -> wdata=0.
REQ-031 SRAI x5, shamt=4, op1=32'h80000000 -> stall_o=1 for 4 cycles (T..T+3), we=0 T+1..T+4, wdata=32'hF8000000 with we=1, waddr=5 in T+5.
REQ-032 SLLI x6, shamt=0, op1=32'h1234 -> single-cycle result 32'h1234, stall_o=0.
REQ-033 SRLI shamt=8 accepted, rst_i=1 in third SHIFT cycle -> next cycle all outputs 0, stall_o=0; following ADDI x7 op1=1 op2=1 -> wdata=2 one cycle later.
REQ-034 SLLI x8 shamt=1 op1=1, immediately followed by ADDI x9 op1=10 op2=1 -> x8=2 in T+2, x9=11 in T+3; ADDI x0 at any time -> we=0.
